// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the two-requester memory arbiter.
// Requester indices double as array indices for per-port logic.
package mem_arb_pkg;

    localparam int ADDR_W_DFLT = 11;
    localparam int DATA_W_DFLT = 16;
    localparam int NUM_REQ     = 2;

    localparam logic CPU  = 1'b0;
    localparam logic HOST = 1'b1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RESP  = 2'd2
    } arb_state_t;

endpackage

// File: rtl/arb_rr2.sv
// Two-way round-robin pick: a lone request wins outright, a tie goes to
// whichever requester was not granted last.
module arb_rr2
    import mem_arb_pkg::*;
(
    input  logic req_cpu,
    input  logic req_host,
    input  logic last_grant,
    output logic winner
);

    always_comb begin
        winner = CPU;
        if (req_cpu && req_host) begin
            winner = ~last_grant;
        end else if (req_host) begin
            winner = HOST;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates CPU and host/loader accesses onto one synchronous RAM port.
// Every access is IDLE (grant) -> ISSUE (mem_en) -> RESP (ack, read data).
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DFLT,
    parameter int DATA_W = DATA_W_DFLT
) (
    input  logic              clk,
    input  logic              reset,

    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_ack,
    output logic [DATA_W-1:0] cpu_rdata,

    input  logic              host_req,
    input  logic              host_we,
    input  logic [ADDR_W-1:0] host_addr,
    input  logic [DATA_W-1:0] host_wdata,
    output logic              host_ack,
    output logic [DATA_W-1:0] host_rdata,
    input  logic              host_lock,

    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,

    output logic              busy,
    output logic              cpu_stall
);

    arb_state_t state, state_nxt;
    logic       grant;
    logic       winner;
    logic       last_grant;
    logic       owner;

    logic              cap_we;
    logic [ADDR_W-1:0] cap_addr;
    logic [DATA_W-1:0] cap_wdata;

    logic [NUM_REQ-1:0]             elig;
    logic [NUM_REQ-1:0]             req_we;
    logic [NUM_REQ-1:0][ADDR_W-1:0] req_addr;
    logic [NUM_REQ-1:0][DATA_W-1:0] req_wdata;
    logic [NUM_REQ-1:0]             ack;
    logic [NUM_REQ-1:0]             rd_upd;
    logic [NUM_REQ-1:0][DATA_W-1:0] rdata_q;
    logic [NUM_REQ-1:0][DATA_W-1:0] rdata;

    // The lock masks the CPU only; a CPU access already granted still runs out.
    assign elig[CPU]  = cpu_req & ~host_lock;
    assign elig[HOST] = host_req;

    assign req_we[CPU]     = cpu_we;
    assign req_we[HOST]    = host_we;
    assign req_addr[CPU]   = cpu_addr;
    assign req_addr[HOST]  = host_addr;
    assign req_wdata[CPU]  = cpu_wdata;
    assign req_wdata[HOST] = host_wdata;

    arb_rr2 u_rr (
        .req_cpu    (elig[CPU]),
        .req_host   (elig[HOST]),
        .last_grant (last_grant),
        .winner     (winner)
    );

    always_comb begin
        state_nxt = state;
        grant     = 1'b0;
        case (state)
            IDLE: begin
                if (|elig) begin
                    state_nxt = ISSUE;
                    grant     = 1'b1;
                end
            end
            ISSUE:   state_nxt = RESP;
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state      <= IDLE;
            last_grant <= HOST;
            owner      <= CPU;
            cap_we     <= 1'b0;
            cap_addr   <= '0;
            cap_wdata  <= '0;
        end else begin
            state <= state_nxt;
            if (grant) begin
                owner      <= winner;
                last_grant <= winner;
                cap_we     <= req_we[winner];
                cap_addr   <= req_addr[winner];
                cap_wdata  <= req_wdata[winner];
            end
        end
    end

    // Read data is forwarded straight from the RAM in RESP, then held.
    for (genvar i = 0; i < NUM_REQ; i++) begin : g_port
        assign ack[i]    = (state == RESP) && (owner == 1'(i));
        assign rd_upd[i] = ack[i] & ~cap_we;
        assign rdata[i]  = rd_upd[i] ? mem_rdata : rdata_q[i];

        always_ff @(posedge clk) begin
            if (!reset) begin
                rdata_q[i] <= '0;
            end else if (rd_upd[i]) begin
                rdata_q[i] <= mem_rdata;
            end
        end
    end

    assign cpu_ack    = ack[CPU];
    assign host_ack   = ack[HOST];
    assign cpu_rdata  = rdata[CPU];
    assign host_rdata = rdata[HOST];

    assign mem_en    = (state == ISSUE);
    assign mem_we    = mem_en & cap_we;
    assign mem_addr  = cap_addr;
    assign mem_wdata = cap_wdata;

    assign busy      = (state != IDLE);
    assign cpu_stall = cpu_req & ~cpu_ack;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: transaction-level model plus directed scenarios,
// then randomized traffic with locks and resets.
`timescale 1ns/1ps
module tb_mem_arbiter;
    localparam int AW = 11;
    localparam int DW = 16;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          cpu_req = 1'b0, cpu_we = 1'b0;
    logic [AW-1:0] cpu_addr = '0;
    logic [DW-1:0] cpu_wdata = '0;
    logic          host_req = 1'b0, host_we = 1'b0, host_lock = 1'b0;
    logic [AW-1:0] host_addr = '0;
    logic [DW-1:0] host_wdata = '0;
    logic          cpu_ack, host_ack, mem_en, mem_we, busy, cpu_stall;
    logic [DW-1:0] cpu_rdata, host_rdata, mem_wdata, mem_rdata;
    logic [AW-1:0] mem_addr;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    mem_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clk(clk), .reset(reset),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata),
        .host_req(host_req), .host_we(host_we), .host_addr(host_addr), .host_wdata(host_wdata),
        .host_ack(host_ack), .host_rdata(host_rdata), .host_lock(host_lock),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .busy(busy), .cpu_stall(cpu_stall)
    );

    // Synchronous RAM behind the arbiter
    logic [DW-1:0] ram [0:(1<<AW)-1] = '{default: '0};
    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) ram[mem_addr] <= mem_wdata;
            else        mem_rdata     <= ram[mem_addr];
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Transaction model: cycles left in the current access (2 = address
    // phase, 1 = response phase), and the contents memory should hold.
    logic [DW-1:0] ref_mem [0:(1<<AW)-1] = '{default: '0};
    int            m_cnt = 0;
    logic          m_last = 1'b1, m_who = 1'b0, m_we = 1'b0;
    logic [AW-1:0] m_addr = '0;
    logic [DW-1:0] m_wdata = '0;
    logic [DW-1:0] exp_rd [2] = '{default: '0};
    bit            model_ok = 1'b0;

    initial begin
        forever begin
            @(posedge clk);
            if (m_cnt == 2 && m_we) ref_mem[m_addr] = m_wdata;
            if (!reset) begin
                m_cnt = 0; m_last = 1'b1; exp_rd[0] = '0; exp_rd[1] = '0; model_ok = 1'b1;
            end else if (m_cnt == 2) begin
                m_cnt = 1;
                if (!m_we) exp_rd[m_who] = ref_mem[m_addr];
            end else if (m_cnt == 1) begin
                m_cnt = 0;
            end else begin
                bit c, h;
                c = cpu_req && !host_lock;
                h = host_req;
                if (c || h) begin
                    m_who   = (c && h) ? !m_last : h;
                    m_last  = m_who;
                    m_cnt   = 2;
                    m_we    = m_who ? host_we    : cpu_we;
                    m_addr  = m_who ? host_addr  : cpu_addr;
                    m_wdata = m_who ? host_wdata : cpu_wdata;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (model_ok) begin
            chk("busy",      32'(busy),      32'(m_cnt != 0));
            chk("mem_en",    32'(mem_en),    32'(m_cnt == 2));
            chk("mem_we",    32'(mem_we),    32'(m_cnt == 2 && m_we));
            if (m_cnt == 2) begin
                chk("mem_addr", 32'(mem_addr), 32'(m_addr));
                if (m_we) chk("mem_wdata", 32'(mem_wdata), 32'(m_wdata));
            end
            chk("cpu_ack",    32'(cpu_ack),    32'(m_cnt == 1 && m_who == 1'b0));
            chk("host_ack",   32'(host_ack),   32'(m_cnt == 1 && m_who == 1'b1));
            chk("cpu_rdata",  32'(cpu_rdata),  32'(exp_rd[0]));
            chk("host_rdata", 32'(host_rdata), 32'(exp_rd[1]));
            chk("cpu_stall",  32'(cpu_stall),  32'(cpu_req && !(m_cnt == 1 && m_who == 1'b0)));
        end
    end

    // All tasks return at a falling edge; callers drive #1 later.
    task automatic wait_ack(input bit who, input string nm);
        int k = 0;
        do begin
            @(negedge clk); k++;
        end while (!(who ? host_ack : cpu_ack) && k < 30);
        chk(nm, 32'(who ? host_ack : cpu_ack), 1);
    endtask

    task automatic wait_idle();
        int k = 0;
        do begin
            @(negedge clk); k++;
        end while (busy && k < 10);
        chk("wait_idle", 32'(busy), 0);
    endtask

    task automatic do_reset();
        #1 reset = 1'b0;
        repeat (2) @(negedge clk);
        #1 reset = 1'b1;
        @(negedge clk);
    endtask

    task automatic host_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
        #1 host_req = 1'b1; host_we = 1'b1; host_addr = a; host_wdata = d;
        wait_ack(1'b1, "host_write_ack");
        #1 host_req = 1'b0;
        wait_idle();
    endtask

    initial begin
        int hc, cc, k;
        repeat (3) @(negedge clk);
        chk("rst_mem_en",    32'(mem_en),    0);
        chk("rst_mem_addr",  32'(mem_addr),  0);
        chk("rst_mem_wdata", 32'(mem_wdata), 0);
        chk("rst_cpu_rdata", 32'(cpu_rdata), 0);
        chk("rst_busy",      32'(busy),      0);
        #1 reset = 1'b1;
        @(negedge clk);

        // CPU read of a host-preloaded word
        host_write(11'h005, 16'h1234);
        #1 cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 11'h005;
        @(negedge clk);
        chk("rd_mem_en",   32'(mem_en),   1);
        chk("rd_mem_addr", 32'(mem_addr), 32'h005);
        @(negedge clk);
        chk("rd_cpu_ack",   32'(cpu_ack),   1);
        chk("rd_cpu_rdata", 32'(cpu_rdata), 32'h1234);
        chk("rd_host_ack",  32'(host_ack),  0);
        #1 cpu_req = 1'b0;
        wait_idle();

        // Simultaneous writes straight after reset: CPU first
        do_reset();
        #1 cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 11'h010; cpu_wdata = 16'hAAAA;
        host_req = 1'b1; host_we = 1'b1; host_addr = 11'h011; host_wdata = 16'h5555;
        @(negedge clk);
        chk("tie_mem_addr", 32'(mem_addr), 32'h010);
        @(negedge clk);
        chk("tie_cpu_ack",  32'(cpu_ack),  1);
        chk("tie_host_ack", 32'(host_ack), 0);
        #1 cpu_req = 1'b0;
        k = 0;
        do begin @(negedge clk); k++; end while (!host_ack && k < 10);
        chk("ack_gap", 32'(k), 3);
        #1 host_req = 1'b0;
        wait_idle();
        chk("ram_010", 32'(ram[11'h010]), 32'hAAAA);
        chk("ram_011", 32'(ram[11'h011]), 32'h5555);

        // Host lock: four host reads, CPU starved, then CPU wins after unlock
        #1 host_lock = 1'b1;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 11'h005;
        host_req = 1'b1; host_we = 1'b0; host_addr = 11'h011;
        hc = 0; cc = 0;
        for (int i = 0; i < 11; i++) begin
            @(negedge clk);
            hc += int'(host_ack);
            cc += int'(cpu_ack);
        end
        chk("lock_host_acks", 32'(hc), 4);
        chk("lock_cpu_acks",  32'(cc), 0);
        #1 host_lock = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("unlock_grant_addr", 32'(mem_addr), 32'h005);
        @(negedge clk);
        chk("unlock_cpu_ack",   32'(cpu_ack),   1);
        chk("unlock_cpu_rdata", 32'(cpu_rdata), 32'h1234);
        #1 cpu_req = 1'b0; host_req = 1'b0;
        wait_idle();

        // Address change during ISSUE is ignored
        host_write(11'h020, 16'hBEEF);
        host_write(11'h030, 16'h0F0F);
        #1 cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 11'h020;
        @(negedge clk);
        chk("cap_mem_addr", 32'(mem_addr), 32'h020);
        #1 cpu_addr = 11'h030;
        @(negedge clk);
        chk("cap_cpu_rdata", 32'(cpu_rdata), 32'hBEEF);
        #1 cpu_req = 1'b0;
        wait_idle();

        // Reset in ISSUE of a host write aborts it
        do_reset();
        #1 host_req = 1'b1; host_we = 1'b1; host_addr = 11'h040; host_wdata = 16'h7777;
        @(negedge clk);
        chk("abort_issue", 32'(mem_en), 1);
        #1 reset = 1'b0;
        @(negedge clk);
        chk("abort_host_ack", 32'(host_ack), 0);
        chk("abort_mem_en",   32'(mem_en),   0);
        chk("abort_busy",     32'(busy),     0);
        #1 reset = 1'b1;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 11'h005;
        host_req = 1'b1; host_we = 1'b0; host_addr = 11'h020;
        @(negedge clk);
        chk("abort_tie_addr", 32'(mem_addr), 32'h005);
        @(negedge clk);
        chk("abort_tie_ack", 32'(cpu_ack), 1);
        #1 cpu_req = 1'b0;
        wait_ack(1'b1, "abort_host_next");
        #1 host_req = 1'b0;
        wait_idle();

        // Randomized traffic, locks and resets
        for (int i = 0; i < 2000; i++) begin
            #1;
            reset      = ($urandom_range(99) >= 2);
            host_lock  = ($urandom_range(99) < 20);
            cpu_req    = ($urandom_range(99) < 60);
            cpu_we     = 1'($urandom);
            cpu_addr   = AW'($urandom_range(15));
            cpu_wdata  = DW'($urandom);
            host_req   = ($urandom_range(99) < 50);
            host_we    = 1'($urandom);
            host_addr  = AW'($urandom_range(15));
            host_wdata = DW'($urandom);
            @(negedge clk);
        end
        #1 reset = 1'b1; cpu_req = 1'b0; host_req = 1'b0; host_lock = 1'b0;
        repeat (4) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
